// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response bus bundle for alu_arbiter.
// Signals:
//   reqValid/reqReady, reqOpcode0/1, reqOperandA0/1, reqOperandB0/1 : two requesters
//   Opcode, Operand1, Operand2, Result, flagC, flagZ                   : ALU side
//   rspValid/rspReady, rspId, rspResult, rspFlagC, rspFlagZ, rspErr    : response
// Modports: slave = arbiter, master = requesters / ALU / response sink.
interface alu_arbiter_if;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [2:0]  reqOpcode0;
    logic [2:0]  reqOpcode1;
    logic [7:0]  reqOperandA0;
    logic [7:0]  reqOperandA1;
    logic [7:0]  reqOperandB0;
    logic [7:0]  reqOperandB1;
    logic [2:0]  Opcode;
    logic [7:0]  Operand1;
    logic [7:0]  Operand2;
    logic [15:0] Result;
    logic        flagC;
    logic        flagZ;
    logic        rspValid;
    logic        rspReady;
    logic        rspId;
    logic [15:0] rspResult;
    logic        rspFlagC;
    logic        rspFlagZ;
    logic        rspErr;
    modport slave (
        input  reqValid, reqOpcode0, reqOpcode1, reqOperandA0, reqOperandA1,
               reqOperandB0, reqOperandB1, Result, flagC, flagZ, rspReady,
        output reqReady, Opcode, Operand1, Operand2, rspValid, rspId,
               rspResult, rspFlagC, rspFlagZ, rspErr
    );
    modport master (
        output reqValid, reqOpcode0, reqOpcode1, reqOperandA0, reqOperandA1,
               reqOperandB0, reqOperandB1, Result, flagC, flagZ, rspReady,
        input  reqReady, Opcode, Operand1, Operand2, rspValid, rspId,
               rspResult, rspFlagC, rspFlagZ, rspErr
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters.
// Ports: clk, rst (async active-high), s (alu_arbiter_if.slave: request,
//   ALU and response buses). Parameter ALU_WAIT (1..15): EXEC length in cycles.
// Optional macro ALU_ARB_OPCHK_EN: opcodes above 3'b100 are rejected with rspErr.
module alu_arbiter #(
    parameter int ALU_WAIT = 1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave s
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state;
    logic        ptr, gnt, hs, bad;
    logic        vld_q, id_q, c_q, z_q;
    logic [3:0]  cnt;
    logic [2:0]  op_q, op_sel;
    logic [7:0]  a_q, b_q, a_sel, b_sel;
    logic [15:0] res_q;

    // Pointer only matters when both request; a lone requester always wins.
    assign gnt        = (s.reqValid == 2'b11) ? ptr : s.reqValid[1];
    assign s.reqReady = (state == IDLE && !rst && s.reqValid != 2'b00) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign hs         = |(s.reqValid & s.reqReady);
    assign op_sel     = gnt ? s.reqOpcode1 : s.reqOpcode0;
    assign a_sel      = gnt ? s.reqOperandA1 : s.reqOperandA0;
    assign b_sel      = gnt ? s.reqOperandB1 : s.reqOperandB0;

    assign s.Opcode    = op_q;
    assign s.Operand1  = a_q;
    assign s.Operand2  = b_q;
    assign s.rspValid  = vld_q;
    assign s.rspId     = id_q;
    assign s.rspResult = res_q;
    assign s.rspFlagC  = c_q;
    assign s.rspFlagZ  = z_q;

`ifdef ALU_ARB_OPCHK_EN
    logic err_q;
    assign bad      = op_sel > 3'b100;
    assign s.rspErr = err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            err_q <= 1'b0;
        else if (hs)
            err_q <= bad;
`else
    assign bad      = 1'b0;
    assign s.rspErr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 8'd0;
            b_q   <= 8'd0;
            vld_q <= 1'b0;
            id_q  <= 1'b0;
            res_q <= 16'd0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    id_q <= gnt;
                    ptr  <= ~gnt;
                    if (bad) begin
                        // Rejected op: ALU bus keeps its old values, respond next cycle.
                        state <= RESP;
                        vld_q <= 1'b1;
                        res_q <= 16'd0;
                        c_q   <= 1'b0;
                        z_q   <= 1'b0;
                    end else begin
                        state <= EXEC;
                        op_q  <= op_sel;
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        cnt   <= 4'(ALU_WAIT - 1);
                    end
                end
                EXEC: if (cnt == 4'd0) begin
                    state <= RESP;
                    vld_q <= 1'b1;
                    res_q <= s.Result;
                    c_q   <= s.flagC;
                    z_q   <= s.flagZ;
                end else
                    cnt <= cnt - 4'd1;
                default: if (s.rspReady) begin
                    state <= IDLE;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (ALU_WAIT 1 and 4).
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if a();
    alu_arbiter_if b();

    alu_arbiter #(.ALU_WAIT(1)) dut1 (.clk(clk), .rst(rst), .s(a));
    alu_arbiter #(.ALU_WAIT(4)) dut4 (.clk(clk), .rst(rst), .s(b));

    always #5 clk = ~clk;

    // ALU stand-in: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, others a marker value.
    function automatic logic [17:0] alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] r;
        r = (op == 3'd0) ? {8'd0, x} + {8'd0, y} :
            (op == 3'd1) ? {8'd0, x} - {8'd0, y} :
            (op == 3'd2) ? {8'd0, x} * {8'd0, y} :
            (op == 3'd3) ? {8'd0, x & y} :
            (op == 3'd4) ? {8'd0, x | y} : 16'h1234;
        return {r, |r[15:8], r == 16'd0};
    endfunction

    assign {a.Result, a.flagC, a.flagZ} = alu(a.Opcode, a.Operand1, a.Operand2);
    assign {b.Result, b.flagC, b.flagZ} = alu(b.Opcode, b.Operand1, b.Operand2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a.reqValid = 2'b00; a.rspReady = 1'b1;
        a.reqOpcode0 = 3'd0; a.reqOperandA0 = 8'd0; a.reqOperandB0 = 8'd0;
        a.reqOpcode1 = 3'd0; a.reqOperandA1 = 8'd0; a.reqOperandB1 = 8'd0;
        b.reqValid = 2'b00; b.rspReady = 1'b1;
        b.reqOpcode0 = 3'd0; b.reqOperandA0 = 8'd0; b.reqOperandB0 = 8'd0;
        b.reqOpcode1 = 3'd0; b.reqOperandA1 = 8'd0; b.reqOperandB1 = 8'd0;
        tick();
        a.reqValid = 2'b11; b.reqValid = 2'b11;
        #1;
        check("rst_ready_a", a.reqReady, 2'b00);
        check("rst_ready_b", b.reqReady, 2'b00);
        check("rst_rspvalid", a.rspValid, 0);
        check("rst_opcode", a.Opcode, 0);
        check("rst_result", a.rspResult, 0);
        check("rst_err", a.rspErr, 0);
        tick();
        rst = 1'b0; a.reqValid = 2'b00; b.reqValid = 2'b00;

        a.reqValid = 2'b01; a.reqOpcode0 = 3'd0; a.reqOperandA0 = 8'hAA; a.reqOperandB0 = 8'hCC;
        #1;
        check("add_ready", a.reqReady, 2'b01);
        tick();
        a.reqValid = 2'b00;
        check("add_exec_valid", a.rspValid, 0);
        tick();
        check("add_valid", a.rspValid, 1);
        check("add_result", a.rspResult, 16'h0176);
        check("add_c", a.rspFlagC, 1);
        check("add_z", a.rspFlagZ, 0);
        check("add_id", a.rspId, 0);
        check("add_err", a.rspErr, 0);
        tick();
        check("add_idle_valid", a.rspValid, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        a.reqValid = 2'b11;
        a.reqOpcode0 = 3'd2; a.reqOperandA0 = 8'h55; a.reqOperandB0 = 8'h33;
        a.reqOpcode1 = 3'd3; a.reqOperandA1 = 8'hCC; a.reqOperandB1 = 8'hAA;
        #1;
        check("rr_first_ready", a.reqReady, 2'b01);
        tick();
        a.reqValid = 2'b10;
        check("rr_exec_ready", a.reqReady, 2'b00);
        tick();
        check("mul_result", a.rspResult, 16'h10EF);
        check("mul_id", a.rspId, 0);
        check("mul_c", a.rspFlagC, 1);
        tick();
        check("rr_second_ready", a.reqReady, 2'b10);
        tick();
        a.reqValid = 2'b00;
        tick();
        check("and_result", a.rspResult, 16'h0088);
        check("and_id", a.rspId, 1);
        check("and_c", a.rspFlagC, 0);
        tick();
        a.reqValid = 2'b11;
        a.reqOpcode0 = 3'd0; a.reqOperandA0 = 8'h01; a.reqOperandB0 = 8'h02;
        #1;
        check("rr_third_ready", a.reqReady, 2'b01);

        tick();
        a.reqValid = 2'b10; a.rspReady = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", a.rspValid, 1);
            check("hold_result", a.rspResult, 16'h0003);
            check("hold_id", a.rspId, 0);
            check("hold_ready", a.reqReady, 2'b00);
            tick();
        end
        a.rspReady = 1'b1;
        check("hold_last_valid", a.rspValid, 1);
        tick();
        check("hold_done_valid", a.rspValid, 0);
        check("hold_req1_ready", a.reqReady, 2'b10);

        tick();
        rst = 1'b1;
        #1;
        check("abort_valid", a.rspValid, 0);
        check("abort_opcode", a.Opcode, 0);
        check("abort_ready", a.reqReady, 2'b00);
        tick();
        check("abort_valid2", a.rspValid, 0);
        rst = 1'b0;
        #1;
        check("abort_regrant_ready", a.reqReady, 2'b10);
        tick();
        a.reqValid = 2'b00;
        check("abort_exec_valid", a.rspValid, 0);
        tick();
        check("regrant_valid", a.rspValid, 1);
        check("regrant_result", a.rspResult, 16'h0088);
        check("regrant_id", a.rspId, 1);

        tick();
        a.reqValid = 2'b01; a.reqOpcode0 = 3'd1; a.reqOperandA0 = 8'h05; a.reqOperandB0 = 8'h05;
        tick();
        a.reqValid = 2'b00;
        tick();
        check("sub_result", a.rspResult, 16'h0000);
        check("sub_z", a.rspFlagZ, 1);
        check("sub_c", a.rspFlagC, 0);

        tick();
        a.reqValid = 2'b01; a.reqOpcode0 = 3'd7; a.reqOperandA0 = 8'h12; a.reqOperandB0 = 8'h34;
        tick();
        a.reqValid = 2'b00;
`ifdef ALU_ARB_OPCHK_EN
        check("err_valid", a.rspValid, 1);
        check("err_flag", a.rspErr, 1);
        check("err_result", a.rspResult, 16'h0000);
        check("err_z", a.rspFlagZ, 0);
        check("err_opcode", a.Opcode, 3'd1);
`else
        check("err_exec_valid", a.rspValid, 0);
        tick();
        check("err_valid", a.rspValid, 1);
        check("err_flag", a.rspErr, 0);
        check("err_result", a.rspResult, 16'h1234);
        check("err_opcode", a.Opcode, 3'd7);
`endif
        tick();
        check("err_idle_valid", a.rspValid, 0);

        b.reqValid = 2'b01; b.reqOpcode0 = 3'd4; b.reqOperandA0 = 8'hF0; b.reqOperandB0 = 8'h0F;
        #1;
        check("w4_ready", b.reqReady, 2'b01);
        tick();
        b.reqValid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check("w4_valid", b.rspValid, 0);
            check("w4_opcode", b.Opcode, 3'd4);
            check("w4_op1", b.Operand1, 8'hF0);
            check("w4_op2", b.Operand2, 8'h0F);
            tick();
        end
        check("w4_valid_on", b.rspValid, 1);
        check("w4_result", b.rspResult, 16'h00FF);
        check("w4_c", b.rspFlagC, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter ALU_WAIT, default 1, giving the cycles between ALU operand drive and result capture (legal 1..15).
REQ-002 The module SHALL have these ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous and active-high
- reqValid  input  2  per-requester request valid (bit i = requester i)
- reqReady  output  2  per-requester request accept
- reqOpcode0 / reqOpcode1  input  3  requester opcode
- reqOperandA0 / reqOperandA1  input  8  requester first operand
- reqOperandB0 / reqOperandB1  input  8  requester second operand
- Opcode  output  3  to ALU Opcode
- Operand1  output  8  to ALU Operand1
- Operand2  output  8  to ALU Operand2
- Result  input  16  from ALU Result
- flagC  input  1  from ALU carry flag
- flagZ  input  1  from ALU zero flag
- rspValid  output  1  response valid
- rspReady  input  1  response accept
- rspId  output  1  requester index owning the response
- rspResult  output  16  captured ALU result
- rspFlagC  output  1  captured carry
- rspFlagZ  output  1  captured zero
- rspErr  output  1  illegal-opcode indication

Function
REQ-003 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-004 In IDLE with reqValid!=0, the arbiter SHALL assert exactly one reqReady bit combinationally in that cycle; a handshake is reqValid[i]&reqReady[i].
REQ-005 Arbitration SHALL be round-robin: with both valid, the requester named by the priority pointer wins; with one valid, that one wins regardless of the pointer.
REQ-006 On each grant the pointer SHALL move to the non-granted requester.
REQ-007 reqReady SHALL be 0 in EXEC and RESP; requests held there SHALL wait without loss.
REQ-008 On handshake the block SHALL register opcode, operands and winner id, and enter EXEC.
REQ-009 Opcode/Operand1/Operand2 SHALL be driven only from registers, held stable throughout EXEC and RESP.
REQ-010 EXEC SHALL last exactly ALU_WAIT cycles via a 4-bit down-counter; on its last cycle, Result/flagC/flagZ SHALL be captured into rspResult/rspFlagC/rspFlagZ and the FSM SHALL enter RESP.
REQ-011 In RESP, rspValid SHALL be 1 and all rsp* outputs SHALL hold stable until rspValid&rspReady, then the FSM SHALL return to IDLE.
REQ-012 Latency: handshake in cycle N gives rspValid first high in cycle N+ALU_WAIT+1; with rspReady held 1, a new grant is possible in cycle N+ALU_WAIT+2.
REQ-013 rspValid SHALL be 0 in IDLE and EXEC.
REQ-014 Values SHALL pass through unmodified: no width change, no flag recomputation.

Reset
REQ-015 rst high SHALL immediately force: state IDLE; pointer to requester 0; counter 0; Opcode, Operand1, Operand2 to 0; rspValid, rspId, rspResult, rspFlagC, rspFlagZ, rspErr to 0.
REQ-016 Reset in EXEC or RESP SHALL abort the operation with no response emitted; requests SHALL be re-arbitrated from IDLE after release.
REQ-017 reqReady SHALL be 0 while rst is high.

Configuration
REQ-018 With macro ALU_ARB_OPCHK_EN defined, an accepted opcode above 3'b100 SHALL NOT be issued: Opcode/Operand1/Operand2 stay at previous values, the FSM goes directly to RESP the next cycle with rspErr=1 and rspResult, rspFlagC, rspFlagZ all 0.
REQ-019 Without ALU_ARB_OPCHK_EN, every opcode SHALL be issued normally and rspErr SHALL be tied 0.

Verification
REQ-020 Req0 ADD 0xAA,0xCC, ALU_WAIT=1, rspReady=1 -> rspValid 2 cycles after handshake, rspResult=0x0176, rspFlagC=1, rspId=0.
REQ-021 Both valid after reset, req0 MUL 0x55,0x33 and req1 AND 0xCC,0xAA -> req0 served first (0x10EF), then req1 (0x0088, rspId=1); next simultaneous pair is granted req0 first.
REQ-022 rspReady low for 5 cycles in RESP -> rspValid and all rsp* held constant; reqReady=0 throughout; response completes on the 6th cycle.
REQ-023 Assert rst in EXEC -> rspValid never asserted for that op; after release the pending request is granted again and answered correctly.
REQ-024 With ALU_ARB_OPCHK_EN, opcode 3'b111 -> rspErr=1, rspResult=0x0000, 1 cycle after handshake; without it -> rspErr=0 and rspResult equals Result from the ALU.
REQ-025 ALU_WAIT=4 -> rspValid exactly 5 cycles after handshake; Opcode/Operand1/Operand2 stable across all EXEC cycles.
